gate_bist: RTL and testbench

GATE_BIST -- requirements
Module: gate_bist

---
 rtl/gate_bist_pkg.sv | 19 +
 rtl/gate_bist_timer.sv | 27 ++
 rtl/gate_bist.sv | 115 +++++++++++
 tb/tb_gate_bist.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// gate_bist shared types: FSM state encoding and two-input truth tables.
// Truth table bit i is the expected Y for the vector index {A,B} = i.
package gate_bist_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t APPLY  = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int CNT_W = 4;

  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/gate_bist_timer.sv
// gate_bist settle counter: loadable down-counter that stops at zero.
// The zero flag tells the FSM the applied vector has settled.
module gate_bist_timer
  import gate_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_bist.sv
// gate_bist: exhaustive 2-input gate self-test against the EXPECT truth table.
// Optional GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] EXPECT = 4'b0111,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] y_log,
  output logic [3:0] fail_mask
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

  state_t     state;
  state_t     state_n;
  logic [1:0] idx;
  logic       t_load;
  logic       t_dec;
  logic       t_zero;
  logic       mism;
  logic       stop;
  logic       drive;
  logic [3:0] fail_next;

  gate_bist_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (LOAD_VAL),
    .zero     (t_zero)
  );

  assign mism      = (dut_y != EXPECT[idx]);
  assign fail_next = fail_mask | (4'(mism) << idx);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          state_n = APPLY;
          t_load  = 1'b1;
        end
      end
      (state == APPLY): begin
        if (t_zero)
          state_n = SAMPLE;
        else
          t_dec = 1'b1;
      end
      (state == SAMPLE): begin
        if (idx == 2'd3 || stop) begin
          state_n = DONE;
        end else begin
          state_n = APPLY;
          t_load  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      y_log     <= 4'd0;
      fail_mask <= 4'd0;
      pass      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        idx       <= 2'd0;
        y_log     <= 4'd0;
        fail_mask <= 4'd0;
        pass      <= 1'b0;
      end
      if (state == SAMPLE) begin
        y_log[idx] <= dut_y;
        fail_mask  <= fail_next;
        // pass lands together with done so it is valid in the done cycle
        if (state_n == DONE)
          pass <= (fail_next == 4'd0);
        else
          idx <= idx + 2'd1;
      end
    end
  end

  assign drive = (state == APPLY) || (state == SAMPLE);
  assign dut_a = drive & idx[1];
  assign dut_b = drive & idx[0];
  assign busy  = drive;
  assign done  = (state == DONE);

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed runs of gate_bist against modelled gates.
// Scoreboard queues hold expected results per run, popped at done.
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         mode;
  logic       a0, b0, y0, busy0, done0, pass0;
  logic [3:0] ylog0, fm0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [3:0] ylog1, fm1;

  typedef struct {
    logic [3:0] ylog;
    logic [3:0] fail;
    logic       pass;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    y0 = 1'b0;
    case (mode)
      0:       y0 = ~(a0 & b0);
      1:       y0 = 1'b1;
      2:       y0 = a0 & b0;
      default: y0 = 1'b0;
    endcase
  end

  assign y1 = a1 & b1;

  gate_bist u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_a     (a0),
    .dut_b     (b0),
    .dut_y     (y0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .y_log     (ylog0),
    .fail_mask (fm0)
  );

  gate_bist #(.EXPECT(AND_TT)) u_and (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_a     (a1),
    .dut_b     (b1),
    .dut_y     (y1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .y_log     (ylog1),
    .fail_mask (fm1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c is the clock period ending at edge c; edge 0 accepts start.
  task automatic run(input int m, input logic [3:0] ey,
                     input logic [3:0] ef, input logic ep,
                     input int ec, input int p1, input int p2);
    exp_t g;
    int n0 = 0, n1 = 0, d0 = 0, d1 = 0;
    logic [3:0] yd0 = 4'hx, fd0 = 4'hx;
    logic pd0 = 1'bx, pd1 = 1'bx;
    q0.push_back('{ey, ef, ep, ec});
    q1.push_back('{AND_TT, 4'b0000, 1'b1, 13});
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 2) chk("busy_run", 32'(busy0), 32'd1);
      if (done0) begin
        n0++; d0 = c; yd0 = ylog0; fd0 = fm0; pd0 = pass0;
      end
      if (done1) begin
        n1++; d1 = c; pd1 = pass1;
      end
      start = (c == p1 || c == p2);
      @(negedge clk);
    end
    start = 1'b0;
    g = q0.pop_front();
    chk("done_cyc", 32'(d0), 32'(g.cyc));
    chk("done_cnt", 32'(n0), 32'd1);
    chk("ylog_done", 32'(yd0), 32'(g.ylog));
    chk("fail_done", 32'(fd0), 32'(g.fail));
    chk("pass_done", 32'(pd0), 32'(g.pass));
    chk("ylog_hold", 32'(ylog0), 32'(g.ylog));
    chk("fail_hold", 32'(fm0), 32'(g.fail));
    chk("pass_hold", 32'(pass0), 32'(g.pass));
    chk("busy_idle", 32'(busy0), 32'd0);
    g = q1.pop_front();
    chk("and_cyc", 32'(d1), 32'(g.cyc));
    chk("and_cnt", 32'(n1), 32'd1);
    chk("and_pass", 32'(pd1), 32'(g.pass));
    chk("and_ylog", 32'(ylog1), 32'(g.ylog));
    chk("and_fail", 32'(fm1), 32'(g.fail));
  endtask

  initial begin
    int dc;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk("reset_out",
        32'({a0, b0, busy0, done0, pass0, ylog0, fm0}), 32'd0);
    // start together with reset must lose
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_prio", 32'(busy0), 32'd0);
    rst = 1'b0;

    run(0, 4'b0111, 4'b0000, 1'b1, 13, 0, 0);
    run(1, 4'b1111, 4'b1000, 1'b0, 13, 0, 0);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    run(2, 4'b0000, 4'b0001, 1'b0, 4, 0, 0);
    run(3, 4'b0000, 4'b0001, 1'b0, 4, 0, 0);
`else
    run(2, 4'b1000, 4'b1111, 1'b0, 13, 0, 0);
    run(3, 4'b0000, 4'b0111, 1'b0, 13, 0, 0);
`endif

    // reset in cycle 6 of a run
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_ylog", 32'(ylog0), 32'h1);
    chk("mid_ab", 32'({a0, b0}), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid",
        32'({a0, b0, busy0, done0, pass0, ylog0, fm0}), 32'd0);
    chk("rst_mid_and",
        32'({a1, b1, busy1, done1, pass1, ylog1, fm1}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idle", 32'(busy0), 32'd0);

    run(0, 4'b0111, 4'b0000, 1'b1, 13, 0, 0);
    run(0, 4'b0111, 4'b0000, 1'b1, 13, 3, 7);

    // start held high through done restarts
    start = 1'b1;
    dc = 0;
    for (int c = 0; c < 30 && !done0; c++) begin
      @(negedge clk);
      dc++;
    end
    chk("hold_done", 32'(done0), 32'd1);
    @(negedge clk);
    chk("hold_idle", 32'({busy0, done0}), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'(busy0), 32'd1);
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
